// File: rtl/lsu_mem_arbiter.sv
// Shares one req/gnt/rvalid data-memory port between NUM_REQ requesters, routing responses in order via a tag FIFO.
// Define LSU_MEM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
module lsu_mem_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int OUTSTANDING_MAX = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_i,
  input  logic [32*NUM_REQ-1:0]   addr_i,
  input  logic [NUM_REQ-1:0]      we_i,
  input  logic [4*NUM_REQ-1:0]    be_i,
  input  logic [32*NUM_REQ-1:0]   wdata_i,
  output logic [NUM_REQ-1:0]      gnt_o,
  output logic [NUM_REQ-1:0]      rvalid_o,
  output logic [31:0]             rdata_o,
  output logic                    mem_req_o,
  output logic [31:0]             mem_addr_o,
  output logic                    mem_we_o,
  output logic [3:0]              mem_be_o,
  output logic [31:0]             mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [31:0]             mem_rdata_i,
  output logic                    err_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = $clog2(OUTSTANDING_MAX);
  localparam int CNT_W = $clog2(OUTSTANDING_MAX + 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   sel_q;
  logic [IDX_W-1:0]   arb_sel;
  logic [IDX_W-1:0]   sel;
  logic               req_int;
  logic               lock_drop;
  logic               push, pop;
  logic               empty, full;
  logic               err_q, err_set;
  logic [PTR_W-1:0]   wptr_q, rptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [IDX_W-1:0]   tag_mem [OUTSTANDING_MAX];
  logic [IDX_W-1:0]   head;
  logic [31:0]        addr_mux, wdata_mux;
  logic               we_mux;
  logic [3:0]         be_mux;

`ifdef LSU_MEM_ARB_FIXED_PRIO_EN
  function automatic logic [IDX_W-1:0] pick_winner(input logic [NUM_REQ-1:0] req);
    logic [IDX_W-1:0] pick;
    logic             found;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        found = 1'b1;
        pick  = IDX_W'(i);
      end
    end
    return pick;
  endfunction

  assign arb_sel = pick_winner(req_i);
`else
  logic [IDX_W-1:0] rr_ptr_q;

  // Scan starts at the pointer and wraps; first active requester wins.
  function automatic logic [IDX_W-1:0] pick_winner(input logic [NUM_REQ-1:0] req,
                                                   input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] k;
    logic             found;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[k]) begin
        found = 1'b1;
        pick  = k;
      end
    end
    return pick;
  endfunction

  assign arb_sel = pick_winner(req_i, rr_ptr_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else if (push) begin
      rr_ptr_q <= (sel == IDX_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
    end
  end
`endif

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(OUTSTANDING_MAX));
  assign sel   = (state_q == LOCKED) ? sel_q : arb_sel;
  assign head  = tag_mem[rptr_q];

  always_comb begin
    state_d   = state_q;
    lock_drop = 1'b0;
    req_int   = 1'b0;
    case (state_q)
      IDLE: begin
        req_int = (|req_i) && !full;
        if (req_int && !mem_gnt_i) state_d = LOCKED;
      end
      LOCKED: begin
        req_int = req_i[sel_q];
        if (!req_i[sel_q]) begin
          state_d   = IDLE;
          lock_drop = 1'b1;
        end else if (mem_gnt_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_mux  = '0;
    we_mux    = 1'b0;
    be_mux    = '0;
    wdata_mux = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (sel == IDX_W'(k)) begin
        addr_mux  = addr_i[32*k +: 32];
        we_mux    = we_i[k];
        be_mux    = be_i[4*k +: 4];
        wdata_mux = wdata_i[32*k +: 32];
      end
    end
  end

  assign mem_req_o   = req_int & ~rst;
  assign mem_addr_o  = rst ? '0 : addr_mux;
  assign mem_we_o    = rst ? 1'b0 : we_mux;
  assign mem_be_o    = rst ? '0 : be_mux;
  assign mem_wdata_o = rst ? '0 : wdata_mux;
  assign rdata_o     = rst ? '0 : mem_rdata_i;
  assign err_o       = err_q & ~rst;

  assign push    = mem_req_o & mem_gnt_i;
  assign pop     = mem_rvalid_i & ~empty & ~rst;
  assign err_set = lock_drop | (mem_gnt_i & ~req_int) | (mem_rvalid_i & empty);

  always_comb begin
    gnt_o    = '0;
    rvalid_o = '0;
    if (push) gnt_o[sel]     = 1'b1;
    if (pop)  rvalid_o[head] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (err_set) err_q <= 1'b1;
    end
  end

  // Held selection only matters once LOCKED, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state_q == IDLE) sel_q <= arb_sel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wptr_q] <= sel;
  end

endmodule
